somador_serial_ctrl: RTL and testbench

- Bit-serial N-bit adder controller. Time-shares one 1-bit full-adder cell across all operand bits, one bit per clock, LSB first.
- Captures the operands on a start pulse, sequences WIDTH add steps through the cell and propagates the carry in a flip-flop.
- Presents a registered sum/carry result with a one-cycle done pulse.
- Sits above the 1-bit adder cells of the 4-bit adder exercise as their sequencer.

---
 rtl/somador_serial_ctrl_pkg.sv | 17 +
 rtl/somador_serial_ctrl_if.sv | 34 +++
 rtl/somador_completo_1bit.sv | 28 ++
 rtl/somador_meio_1bit.sv | 10 +
 rtl/somador_serial_ctrl.sv | 103 ++++++++++
 tb/tb_somador_serial_ctrl.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/somador_serial_ctrl_pkg.sv
// rtl/somador_serial_ctrl_pkg.sv - package with the controller state type and default sizes
package somador_serial_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/somador_serial_ctrl_if.sv
// rtl/somador_serial_ctrl_if.sv - request/result bundle; overflow exists only with SOMADOR_SERIAL_OVERFLOW_EN
interface somador_serial_ctrl_if
  import somador_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    input  overflow,
`endif
    input  busy, done, sum, carryOut
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    output overflow,
`endif
    output busy, done, sum, carryOut
  );
endinterface

// File: rtl/somador_completo_1bit.sv
// rtl/somador_completo_1bit.sv - 1-bit full adder built from two half-adder cells
module somador_completo_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carryOut
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  somador_meio_1bit u_ha0 (
    .i_a     (i_a),
    .i_b     (i_b),
    .o_sum   (w_s0),
    .o_carry (w_c0)
  );

  somador_meio_1bit u_ha1 (
    .i_a     (w_s0),
    .i_b     (i_cin),
    .o_sum   (o_sum),
    .o_carry (w_c1)
  );

  assign o_carryOut = w_c0 | w_c1;
endmodule

// File: rtl/somador_meio_1bit.sv
// rtl/somador_meio_1bit.sv - 1-bit half-adder cell
module somador_meio_1bit (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;
endmodule

// File: rtl/somador_serial_ctrl.sv
// rtl/somador_serial_ctrl.sv - bit-serial adder sequencer; SOMADOR_SERIAL_OVERFLOW_EN adds signed overflow
module somador_serial_ctrl
  import somador_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  somador_serial_ctrl_if.slave bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_carry_out;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_cell_sum;
  logic             w_cell_carry;

  somador_completo_1bit u_cell (
    .i_a        (r_a[0]),
    .i_b        (r_b[0]),
    .i_cin      (r_carry),
    .o_sum      (w_cell_sum),
    .o_carryOut (w_cell_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sum fills from the MSB so that after WIDTH steps bit 0 holds the first cell result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_cell_sum, r_sum[WIDTH-1:1]};
      r_carry <= w_cell_carry;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_carry_out <= w_cell_carry;
    end
  end

`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  logic r_overflow;

  // On the last step r_carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst)         r_overflow <= 1'b0;
    else if (w_last) r_overflow <= r_carry ^ w_cell_carry;
  end

  assign bus.overflow = r_overflow;
`endif

  assign bus.busy     = (r_state == ST_RUN);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.sum      = r_sum;
  assign bus.carryOut = r_carry_out;
endmodule

// File: tb/tb_somador_serial_ctrl.sv
// tb/tb_somador_serial_ctrl.sv - directed self-checking bench for somador_serial_ctrl
module tb_somador_serial_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  somador_serial_ctrl_if #(.WIDTH(4)) bus ();

  somador_serial_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic [3:0] es, input logic ec);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.cin   = ~ci;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 32'(bus.busy), 1);
      check({tag, "_done_early"}, 32'(bus.done), 0);
      tick();
    end
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 0);
    check({tag, "_sum"}, 32'(bus.sum), 32'(es));
    check({tag, "_carry"}, 32'(bus.carryOut), 32'(ec));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_sum_hold"}, 32'(bus.sum), 32'(es));
  endtask

  initial begin
    int dones;
    int accepts;
    int last_acc;
    logic prev_busy;
    logic [3:0] seen_sum;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 4'd7;
    bus.b     = 4'd7;
    bus.cin   = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_carry", 32'(bus.carryOut), 0);
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    check("rst_ovf", 32'(bus.overflow), 0);
`endif
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();

    run_op("add_3_5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0);
    run_op("wrap_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    run_op("wrap_15_15_1", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);

    bus.a     = 4'd2;
    bus.b     = 4'd2;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.a = 4'd1;
    bus.b = 4'd1;
    tick();
    tick();
    bus.start = 1'b0;
    dones    = 0;
    seen_sum = 4'hx;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) begin
        dones++;
        seen_sum = bus.sum;
      end
    end
    check("busy_start_dones", 32'(dones), 1);
    check("busy_start_sum", 32'(seen_sum), 4);

    bus.a     = 4'd9;
    bus.b     = 4'd6;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_sum", 32'(bus.sum), 0);
    check("midrst_carry", 32'(bus.carryOut), 0);
    run_op("after_rst_9_6", 4'd9, 4'd6, 1'b0, 4'd15, 1'b0);

    bus.a     = 4'd1;
    bus.b     = 4'd2;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    dones     = 0;
    accepts   = 0;
    last_acc  = -1;
    prev_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 18) bus.start = 1'b0;
      tick();
      if (bus.done) dones++;
      if (bus.busy && !prev_busy) begin
        accepts++;
        if (last_acc >= 0) check("b2b_period", 32'(i - last_acc), 6);
        last_acc = i;
      end
      prev_busy = bus.busy;
    end
    check("b2b_accepts", 32'(accepts), 3);
    check("b2b_dones", 32'(dones), 3);
    check("b2b_sum", 32'(bus.sum), 3);

`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    run_op("ovf_7_1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0);
    check("ovf_7_1_flag", 32'(bus.overflow), 1);
    run_op("ovf_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    check("ovf_15_1_flag", 32'(bus.overflow), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
